// File: rtl/deflate_token_sched_pkg.sv
// Shared types and constants for the DEFLATE token scheduler and its static
// literal/length encoder.
package deflate_pkg;

  localparam int LEN_MIN = 3;
  localparam int LEN_MAX = 258;
  localparam int EOB_SYM = 256;
  localparam int CHUNK_W = 18;
  localparam int NBITS_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LIT_OUT,
    ST_LEN_OUT,
    ST_DIST_OUT,
    ST_EOB_OUT,
    ST_FLUSH_ACK
  } state_t;

  // Huffman codes are MSB-first while the output stream is LSB-first.
  function automatic logic [8:0] bit_rev(input logic [8:0] code, input logic [3:0] n);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(n)) r[4'(i)] = code[4'(int'(n) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/deflate_token_sched_slht_enc.sv
// Combinational fixed-Huffman encoder for literal/EOB and length symbols:
// returns the reversed code with extra bits stacked above it.
module slht_enc
  import deflate_pkg::*;
(
  input  logic               is_len,
  input  logic [8:0]         sym,
  input  logic [8:0]         len,
  output logic [CHUNK_W-1:0] code,
  output logic [NBITS_W-1:0] nbits
);

  logic [8:0] lsym;
  logic [8:0] code_raw;
  logic [3:0] clen;
  logic [4:0] extra;
  logic [2:0] elen;
  logic [7:0] v;
  int         p;

  always_comb begin
    lsym     = sym;
    code_raw = '0;
    clen     = 4'd0;
    extra    = '0;
    elen     = '0;
    v        = 8'(len - 9'(LEN_MIN));
    p        = 3;
    if (is_len) begin
      if (len == 9'(LEN_MAX)) begin
        lsym = 9'd285;
      end else if (v < 8'd8) begin
        lsym = 9'(257 + int'(v));
      end else begin
        // Each group of four length codes shares one extra-bit count,
        // selected by the position of the leading one of (len - 3).
        for (int i = 3; i < 8; i++) begin
          if (v[3'(i)]) p = i;
        end
        elen  = 3'(p - 2);
        lsym  = 9'(257 + 4 * (p - 1) + int'((v >> (p - 2)) & 8'd3));
        extra = 5'(v & 8'((1 << (p - 2)) - 1));
      end
    end

    if (lsym <= 9'd143) begin
      code_raw = lsym + 9'h030;
      clen     = 4'd8;
    end else if (lsym <= 9'd255) begin
      code_raw = lsym + 9'h100;
      clen     = 4'd9;
    end else if (lsym <= 9'd279) begin
      code_raw = lsym - 9'd256;
      clen     = 4'd7;
    end else begin
      code_raw = lsym - 9'd88;
      clen     = 4'd8;
    end

    code  = CHUNK_W'(bit_rev(code_raw, clen)) | (CHUNK_W'(extra) << clen);
    nbits = NBITS_W'(clen) + NBITS_W'(elen);
  end

endmodule

// File: rtl/deflate_token_sched.sv
// DEFLATE token scheduler: turns literal / length-distance tokens into
// LSB-first bit chunks. Define DTS_EOB_EN to emit end-of-block on flush.
module deflate_token_sched
  import deflate_pkg::*;
#(
  parameter int DICTIONARY_DEPTH_LOG = 16,
  parameter int DATA_WIDTH           = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tok_valid_in,
  output logic                          tok_ready_out,
  input  logic                          tok_is_match_in,
  input  logic [DATA_WIDTH-1:0]         tok_literal_in,
  input  logic [8:0]                    tok_length_in,
  input  logic [DICTIONARY_DEPTH_LOG:0] tok_dist_in,
  input  logic                          flush_in,
  output logic [DICTIONARY_DEPTH_LOG:0] dist_pos_out,
  input  logic [CHUNK_W-1:0]            dist_code_in,
  input  logic [NBITS_W-1:0]            dist_nbits_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHUNK_W-1:0]            out_data,
  output logic [NBITS_W-1:0]            out_bits,
  output logic                          flush_done_out,
  output logic                          proto_err_out
);

  // state       | meaning
  // IDLE        | waiting for a token or a flush request
  // LIT_OUT     | literal chunk presented
  // LEN_OUT     | length chunk presented; distance code captured in first cycle
  // DIST_OUT    | distance chunk presented
  // EOB_OUT     | end-of-block chunk presented (DTS_EOB_EN builds only)
  // FLUSH_ACK   | flush_done_out pulse

  state_t               state_q, state_d;
  logic                 accept, hs;
  logic                 load, valid_d;
  logic [CHUNK_W-1:0]   ld_data;
  logic [NBITS_W-1:0]   ld_bits;
  logic [CHUNK_W-1:0]   enc_data;
  logic [NBITS_W-1:0]   enc_bits;
  logic [8:0]           len_clamped;
  logic                 len_err;
  logic                 cap_pending;
  logic [CHUNK_W-1:0]   hold_code;
  logic [NBITS_W-1:0]   hold_nbits;

  assign tok_ready_out  = (state_q == ST_IDLE);
  assign flush_done_out = (state_q == ST_FLUSH_ACK);
  assign accept         = tok_valid_in && tok_ready_out;
  assign hs             = out_valid && out_ready;

  always_comb begin
    len_clamped = tok_length_in;
    len_err     = 1'b0;
    if (tok_length_in < 9'(LEN_MIN)) begin
      len_clamped = 9'(LEN_MIN);
      len_err     = 1'b1;
    end else if (tok_length_in > 9'(LEN_MAX)) begin
      len_clamped = 9'(LEN_MAX);
      len_err     = 1'b1;
    end
  end

  // With no token offered the encoder sees the end-of-block symbol.
  slht_enc u_enc (
    .is_len (tok_valid_in && tok_is_match_in),
    .sym    (tok_valid_in ? 9'(tok_literal_in) : 9'(EOB_SYM)),
    .len    (len_clamped),
    .code   (enc_data),
    .nbits  (enc_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ld_data = enc_data;
    ld_bits = enc_bits;
    case (state_q)
      ST_IDLE: begin
        if (tok_valid_in) begin
          state_d = tok_is_match_in ? ST_LEN_OUT : ST_LIT_OUT;
          load    = 1'b1;
        end else if (flush_in) begin
`ifdef DTS_EOB_EN
          state_d = ST_EOB_OUT;
          load    = 1'b1;
`else
          state_d = ST_FLUSH_ACK;
`endif
        end
      end
      ST_LIT_OUT:  if (hs) state_d = ST_IDLE;
      ST_LEN_OUT: begin
        if (hs) begin
          state_d = ST_DIST_OUT;
          load    = 1'b1;
          // A handshake in the very first LEN_OUT cycle races the capture.
          ld_data = cap_pending ? dist_code_in : hold_code;
          ld_bits = cap_pending ? dist_nbits_in : hold_nbits;
        end
      end
      ST_DIST_OUT: if (hs) state_d = ST_IDLE;
`ifdef DTS_EOB_EN
      ST_EOB_OUT:  if (hs) state_d = ST_FLUSH_ACK;
`endif
      ST_FLUSH_ACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    valid_d = (state_d != ST_IDLE) && (state_d != ST_FLUSH_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_bits      <= '0;
      dist_pos_out  <= '0;
      cap_pending   <= 1'b0;
      hold_code     <= '0;
      hold_nbits    <= '0;
      proto_err_out <= 1'b0;
    end else begin
      out_valid   <= valid_d;
      cap_pending <= accept && tok_is_match_in;
      if (load) begin
        out_data <= ld_data;
        out_bits <= ld_bits;
      end
      if (accept && tok_is_match_in) begin
        dist_pos_out <= tok_dist_in;
        if (len_err) proto_err_out <= 1'b1;
      end
      if (cap_pending) begin
        hold_code  <= dist_code_in;
        hold_nbits <= dist_nbits_in;
      end
    end
  end

endmodule

// File: tb/tb_deflate_token_sched.sv
// Directed + random scoreboard bench for deflate_token_sched; flush
// expectations follow DTS_EOB_EN.
module tb_deflate_token_sched;

  localparam int DL = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid_in = 1'b0;
  logic          tok_ready_out;
  logic          tok_is_match_in = 1'b0;
  logic [DW-1:0] tok_literal_in = '0;
  logic [8:0]    tok_length_in = '0;
  logic [DL:0]   tok_dist_in = '0;
  logic          flush_in = 1'b0;
  logic [DL:0]   dist_pos_out;
  logic [17:0]   dist_code_in = '0;
  logic [4:0]    dist_nbits_in = '0;
  logic          out_valid;
  logic          out_ready;
  logic [17:0]   out_data;
  logic [4:0]    out_bits;
  logic          flush_done_out;
  logic          proto_err_out;

  logic rdy_man = 1'b1;
  logic rdy_rand = 1'b1;
  logic bp_en = 1'b0;
  assign out_ready = bp_en ? rdy_rand : rdy_man;

  deflate_token_sched #(.DICTIONARY_DEPTH_LOG(DL), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tok_valid_in    (tok_valid_in),
    .tok_ready_out   (tok_ready_out),
    .tok_is_match_in (tok_is_match_in),
    .tok_literal_in  (tok_literal_in),
    .tok_length_in   (tok_length_in),
    .tok_dist_in     (tok_dist_in),
    .flush_in        (flush_in),
    .dist_pos_out    (dist_pos_out),
    .dist_code_in    (dist_code_in),
    .dist_nbits_in   (dist_nbits_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_bits        (out_bits),
    .flush_done_out  (flush_done_out),
    .proto_err_out   (proto_err_out)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [22:0] q[$];
  int          n_flush = 0;
  int          exp_flush = 0;
  logic        exp_err = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_data = '0;
  logic [4:0]  prev_bits = '0;
  logic [22:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int c, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) if ((c & (1 << i)) != 0) r |= 1 << (n - 1 - i);
    return r;
  endfunction

  function automatic logic [22:0] lit_model(input int v);
    if (v < 144) return {5'd8, 18'(rev(48 + v, 8))};
    return {5'd9, 18'(rev(400 + v - 144, 9))};
  endfunction

  function automatic logic [22:0] len_model(input int l);
    int base[29] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 19, 23, 27, 31,
                     35, 43, 51, 59, 67, 83, 99, 115, 131, 163, 195, 227, 258};
    int ext[29]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2,
                     3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 0};
    int lc, k, sym, c, cl;
    lc = (l < 3) ? 3 : (l > 258) ? 258 : l;
    k = 0;
    for (int i = 0; i < 29; i++) if (base[i] <= lc) k = i;
    sym = 257 + k;
    if (sym <= 279) begin c = sym - 256; cl = 7; end
    else begin c = sym - 280 + 192; cl = 8; end
    return {5'(cl + ext[k]), 18'(rev(c, cl) | ((lc - base[k]) << cl))};
  endfunction

  // Scoreboard consumer and hold-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (flush_done_out) n_flush++;
      if (prev_stall && out_valid) begin
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_bits", 32'(out_bits), 32'(prev_bits));
      end
      if (out_valid && out_ready) begin
        n_assert++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL spurious_chunk observed data=0x%0h bits=%0d expected none", out_data, out_bits);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          check("chunk_data", 32'(out_data), 32'(e[17:0]));
          check("chunk_bits", 32'(out_bits), 32'(e[22:18]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bits  = out_bits;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic offer_tok();
    int t = 0;
    tok_valid_in = 1'b1;
    while (!tok_ready_out && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_wait", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    tok_valid_in = 1'b0;
  endtask

  task automatic send_lit(input int v, input logic [22:0] exp);
    q.push_back(exp);
    tok_is_match_in = 1'b0;
    tok_literal_in  = DW'(v);
    offer_tok();
  endtask

  task automatic send_match(input int l, input int d, input logic [17:0] code,
                            input logic [4:0] nb, input logic [22:0] exp_len);
    q.push_back(exp_len);
    q.push_back({nb, code});
    if (l < 3 || l > 258) exp_err = 1'b1;
    tok_is_match_in = 1'b1;
    tok_length_in   = 9'(l);
    tok_dist_in     = (DL+1)'(d);
    offer_tok();
    // Encoder result is valid only in the first LEN_OUT cycle.
    dist_code_in  = code;
    dist_nbits_in = nb;
    check("dist_pos", 32'(dist_pos_out), 32'(d));
    @(posedge clk); #1;
    dist_code_in  = '1;
    dist_nbits_in = '1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || !tok_ready_out) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(t < 300), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_bits", 32'(out_bits), 32'd0);
    check("rst_dist_pos", 32'(dist_pos_out), 32'd0);
    check("rst_flush_done", 32'(flush_done_out), 32'd0);
    check("rst_proto_err", 32'(proto_err_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(tok_ready_out), 32'd1);

    send_lit(8'h41, {5'd8, 18'h0008E});
    wait_drain();
    check("ready_after_lit", 32'(tok_ready_out), 32'd1);
    send_lit(200, {5'd9, 18'h00027});
    send_lit(143, {5'd8, 18'h000FD});
    send_lit(144, {5'd9, 18'h00013});
    wait_drain();

    send_match(3, 1, 18'h0, 5'd5, {5'd7, 18'h00040});
    wait_drain();
    send_match(11, 5, 18'h4, 5'd6, {5'd8, 18'h00048});
    send_match(258, 32768, 18'h2ABCD, 5'd18, {5'd8, 18'h000A3});
    wait_drain();
    check("no_err_legal", 32'(proto_err_out), 32'd0);
    send_match(2, 7, 18'h00015, 5'd5, {5'd7, 18'h00040});
    wait_drain();
    check("err_short", 32'(proto_err_out), 32'd1);
    send_match(300, 9, 18'h00123, 5'd9, {5'd8, 18'h000A3});
    wait_drain();

    // Stall in LEN_OUT with a flush request that must be ignored.
    rdy_man = 1'b0;
    send_match(11, 5, 18'h01234, 5'd13, {5'd8, 18'h00048});
    flush_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_len_data", 32'(out_data), 32'h48);
      check("stall_ready", 32'(tok_ready_out), 32'd0);
      @(posedge clk); #1;
    end
    flush_in = 1'b0;
    rdy_man  = 1'b1;
    wait_drain();

    // Token and flush together: token wins.
    flush_in = 1'b1;
    send_lit(0, {5'd8, 18'h0000C});
    flush_in = 1'b0;
    wait_drain();
    check("flush_ignored", 32'(n_flush), 32'(exp_flush));

`ifdef DTS_EOB_EN
    q.push_back({5'd7, 18'h0});
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    begin
      int t = 0;
      while (!flush_done_out && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("flush_done_seen", 32'(flush_done_out), 32'd1);
    end
`else
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    check("flush_done_pulse", 32'(flush_done_out), 32'd1);
    check("flush_no_chunk", 32'(out_valid), 32'd0);
`endif
    exp_flush++;
    @(posedge clk); #1;
    check("flush_done_low", 32'(flush_done_out), 32'd0);
    check("ready_after_flush", 32'(tok_ready_out), 32'd1);
    check("flush_count", 32'(n_flush), 32'(exp_flush));

    bp_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int v = $urandom_range(0, 255);
        send_lit(v, lit_model(v));
      end else begin
        int l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(3, 258);
        int d = $urandom_range(1, 65536);
        logic [17:0] c = 18'($urandom);
        logic [4:0] nb = 5'($urandom_range(1, 18));
        send_match(l, d, c, nb, len_model(l));
      end
    end
    wait_drain();
    bp_en = 1'b0;
    check("proto_err_random", 32'(proto_err_out), 32'(exp_err));

    // Reset while a length chunk is stalled.
    rdy_man = 1'b0;
    tok_is_match_in = 1'b1;
    tok_length_in   = 9'd1;
    tok_dist_in     = 17'd77;
    offer_tok();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_dist_pos", 32'(dist_pos_out), 32'd0);
    check("mid_rst_proto_err", 32'(proto_err_out), 32'd0);
    q.delete();
    exp_err = 1'b0;
    @(posedge clk); #3;
    rst_n   = 1'b1;
    rdy_man = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(tok_ready_out), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send_lit(255, {5'd9, 18'h001FF});
    wait_drain();

    check("final_flush_count", 32'(n_flush), 32'(exp_flush));
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
